// File: rtl/core_pkg.sv
// Shared encodings for the core pipeline control: stage codes and datapath widths.
package core_pkg;

  localparam int STATE_W = 3;
  localparam int XLEN    = 32;

  // Stage encoding driven on the state bus; code 6 is intentionally unused.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd7
  } state_e;

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-pc logic: sequential increment, branch select and
// misaligned-target detection for the writeback redirect.
module pc_next_unit
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_target,
  output logic            misaligned
);

  // Increment wraps modulo 2^XLEN; a taken branch overrides it.
  always_comb begin
    pc_plus4   = pc + XLEN'(4);
    pc_target  = branch_taken ? branch_target : pc_plus4;
    misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, stalls on
// fetch and memory handshakes, redirects at writeback, and handles halt/resume,
// fetch timeout and misaligned branch targets. All outputs come from registers.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic               halt_req,
  input  logic               mem_op,
  input  logic               mem_done,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic               resume,
  output logic [STATE_W-1:0] state,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    retired,
  output logic               halted,
  output logic               error
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FETCH_TIMEOUT);
  localparam logic             TIMEOUT_EN  = (FETCH_TIMEOUT != 0);

  state_e            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [XLEN-1:0]   retired_reg, retired_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              halted_reg, error_reg;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   pc_target;
  logic              misaligned;

  pc_next_unit u_pc_next (
    .pc            (pc_reg),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_plus4      (pc_plus4),
    .pc_target     (pc_target),
    .misaligned    (misaligned)
  );

  // State, pc, retire count and stall counter; reset acts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= RESET_PC;
      retired_reg <= '0;
      cnt_reg     <= '0;
      halted_reg  <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      cnt_reg     <= cnt_next;
      halted_reg  <= (state_next == ST_HALT);
      error_reg   <= (state_next == ST_ERROR);
    end
  end

  // Next-state logic; each input is only looked at in the stage that owns it.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_FETCH: begin
        if (instr_valid) begin
          // A late instruction on the timeout cycle still proceeds.
          state_next = ST_DECODE;
          cnt_next   = '0;
        end else if (TIMEOUT_EN && (cnt_reg == TIMEOUT_CNT)) begin
          state_next = ST_ERROR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DECODE: state_next = halt_req ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_next = mem_op ? ST_MEM : ST_WB;
      ST_MEM:    if (mem_done) state_next = ST_WB;
      ST_WB: begin
        if (misaligned) begin
          // Bad redirect: leave pc and retire count untouched for debug.
          state_next = ST_ERROR;
        end else begin
          state_next   = ST_FETCH;
          pc_next      = pc_target;
          retired_next = retired_reg + XLEN'(1);
        end
      end
      ST_HALT: begin
        if (resume) begin
          // The halting instruction itself counts as retired.
          state_next   = ST_FETCH;
          pc_next      = pc_plus4;
          retired_next = retired_reg + XLEN'(1);
        end
      end
      default: state_next = ST_ERROR;  // ERROR is absorbing; unused code 6 lands here too
    endcase
  end

  assign state   = state_reg;
  assign pc      = pc_reg;
  assign retired = retired_reg;
  assign halted  = halted_reg;
  assign error   = error_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios followed by random
// input traffic, all compared every cycle against a behavioural reference model.
module tb_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0, halt_req = 1'b0, mem_op = 1'b0, mem_done = 1'b0;
  logic        branch_taken = 1'b0, resume = 1'b0;
  logic [31:0] branch_target = '0;
  logic [2:0]  state;
  logic [31:0] pc, retired;
  logic        halted, error;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: stage name as small integer, plus architectural values.
  int          m_stage;   // 0 fetch,1 decode,2 exec,3 mem,4 wb,5 halt,7 error
  logic [31:0] m_pc, m_ret;
  int          m_stall;

  core_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .halt_req(halt_req),
    .mem_op(mem_op), .mem_done(mem_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .resume(resume), .state(state), .pc(pc),
    .retired(retired), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_stage = 0; m_pc = RST_PC; m_ret = 0; m_stall = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at the edge.
  task automatic model_step();
    case (m_stage)
      0: begin
        if (instr_valid) begin m_stage = 1; m_stall = 0; end
        else if (TO != 0 && m_stall == TO) m_stage = 7;
        else m_stall++;
      end
      1: m_stage = halt_req ? 5 : 2;
      2: m_stage = mem_op ? 3 : 4;
      3: if (mem_done) m_stage = 4;
      4: begin
        if (branch_taken && branch_target[1:0] != 2'b00) m_stage = 7;
        else begin
          m_pc    = branch_taken ? branch_target : m_pc + 32'd4;
          m_ret   = m_ret + 32'd1;
          m_stage = 0;
        end
      end
      5: if (resume) begin m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1; m_stage = 0; end
      default: m_stage = 7;
    endcase
  endtask

  task automatic compare_all();
    check("state",   {29'd0, state}, 32'(m_stage));
    check("pc",      pc, m_pc);
    check("retired", retired, m_ret);
    check("halted",  {31'd0, halted}, {31'd0, m_stage == 5});
    check("error",   {31'd0, error},  {31'd0, m_stage == 7});
  endtask

  task automatic tick(input logic iv, input logic hr, input logic mo, input logic md,
                      input logic bt, input logic [31:0] tg, input logic rs);
    instr_valid = iv; halt_req = hr; mem_op = mo; mem_done = md;
    branch_taken = bt; branch_target = tg; resume = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Plain ALU instruction, optionally ending with a branch.
  task automatic instr(input logic bt, input logic [31:0] tg);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, bt, tg, 0);
  endtask

  initial begin
    logic [31:0] pc0;
    model_reset();
    #2;
    do_reset();

    // Back-to-back ALU instructions with instr_valid held high.
    $display("step: 3 ALU instructions");
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0);
      if (i == 3) check("pc_after_1", pc, 32'h4);
      if (i == 7) check("pc_after_2", pc, 32'h8);
    end
    check("retired_12cyc", retired, 32'd3);

    // Memory instruction, mem_done on the third MEM cycle.
    $display("step: memory instruction");
    pc0 = pc;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    check("mem_enter", {29'd0, state}, 32'd3);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    check("mem_to_wb", {29'd0, state}, 32'd4);
    tick(0, 0, 0, 0, 0, 0, 0);
    check("mem_pc", pc, pc0 + 32'd4);

    // Aligned and misaligned branch.
    $display("step: branch to 0x100");
    instr(1, 32'h100);
    check("br_pc", pc, 32'h100);
    $display("step: branch to 0x102 (misaligned)");
    instr(1, 32'h102);
    check("br_mis_state", {29'd0, state}, 32'd7);
    check("br_mis_pc", pc, 32'h100);
    tick(1, 1, 1, 1, 1, 32'h0, 1);
    check("err_sticky", {31'd0, error}, 32'd1);

    // Fetch timeout and the timeout-cycle race.
    $display("step: fetch timeout");
    do_reset();
    for (int i = 0; i < TO + 1; i++) tick(0, 0, 0, 0, 0, 0, 0);
    check("timeout_err", {29'd0, state}, 32'd7);
    $display("step: instr_valid on timeout cycle");
    do_reset();
    for (int i = 0; i < TO; i++) tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    check("timeout_race", {29'd0, state}, 32'd1);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 32'h1C, 0);

    // Halt at pc 0x20 and resume.
    $display("step: halt/resume");
    instr(0, 32'h0);
    check("halt_pc0", pc, 32'h20);
    pc0 = retired;
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    check("halt_state", {29'd0, state}, 32'd5);
    check("halt_flag", {31'd0, halted}, 32'd1);
    tick(1, 1, 1, 1, 1, 32'h3, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    check("resume_pc", pc, 32'h24);
    check("resume_ret", retired, pc0 + 32'd1);

    // pc wrap at the top of the address space.
    $display("step: pc wrap");
    instr(1, 32'hFFFF_FFFC);
    instr(0, 32'h0);
    check("wrap_pc", pc, 32'h0);

    // Reset in the middle of a memory access.
    $display("step: reset mid-MEM");
    instr(1, 32'h40);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_pc", pc, 32'h40);
    do_reset();

    // Random traffic on every input against the model.
    $display("step: random traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = $urandom;
      if ($urandom_range(0, 9) != 0) tg[1:0] = 2'b00;
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, tg,
           $urandom_range(0, 2) == 0);
      if (m_stage == 7 && $urandom_range(0, 3) == 0) do_reset();
    end
    $display("random done: retired=%0d pc=%h", retired, pc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the core. It drives the 3-bit `state` bus and the 32-bit `pc` consumed by the fetch stage and the downstream decode, execute, memory and writeback stages. It sequences one instruction at a time, stalls on fetch and memory handshakes, and applies branch redirects at writeback. It also handles halt/resume and flags fetch timeouts and misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset.
- FETCH_TIMEOUT, 255, maximum stall cycles in FETCH before entering ERROR; 0 disables the timeout.
- CNT_W, 8, width of the fetch stall counter; must hold FETCH_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  fetch stage has instr_out ready; sampled only in FETCH.
- halt_req  in  1  decoded halt (ebreak/ecall); sampled only in DECODE.
- mem_op  in  1  current instruction is a load/store; sampled only in EXEC.
- mem_done  in  1  memory access complete; sampled only in MEM.
- branch_taken  in  1  redirect pc; sampled only in WB.
- branch_target  in  32  redirect address; sampled only in WB.
- resume  in  1  leave HALT; sampled only in HALT.
- state  out  3  current stage encoding, driven to fetch and the other stages.
- pc  out  32  address of the current instruction.
- retired  out  32  count of completed instructions.
- halted  out  1  high while in HALT.
- error  out  1  high while in ERROR (sticky until reset).

Behaviour:
- State encoding is a registered output: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=7. Code 6 is unused; if reached it goes to ERROR on the next edge.
- Reset (asynchronous, takes effect immediately, including mid-instruction):
  - state=FETCH, pc=RESET_PC, retired=0, stall counter=0.
  - halted=0, error=0.
- FETCH:
  - instr_valid=1: go to DECODE next edge and clear the stall counter.
  - Otherwise the stall counter increments.
  - When FETCH_TIMEOUT!=0 and the counter equals FETCH_TIMEOUT with instr_valid still 0, go to ERROR.
  - instr_valid=1 arriving on the timeout cycle wins: go to DECODE.
- DECODE: one cycle. halt_req=1 goes to HALT (pc unchanged, retired unchanged); otherwise go to EXEC.
- EXEC: one cycle. mem_op=1 goes to MEM, else WB.
- MEM: wait for mem_done=1, then go to WB. No timeout.
- WB: one cycle.
  - Next pc = branch_taken ? branch_target : pc+4. The add is modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0.
  - retired increments modulo 2^32.
  - Then go to FETCH.
  - If branch_taken=1 and branch_target[1:0]!=0: go to ERROR instead. pc and retired are not updated.
- HALT: halted=1. resume=1 goes to FETCH with pc=pc+4 and retired+1, so the halt instruction counts as retired. Otherwise stay.
- ERROR: error=1. Absorbing; only rst exits.
- Inputs outside their sampling state are ignored. Simultaneous assertion of every input never changes the transition order above.
- Latency: a non-memory instruction with instr_valid already high takes exactly 4 cycles (FETCH, DECODE, EXEC, WB). A memory instruction takes 5 + (mem_done wait) cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `core_pkg`:
  - state encoding localparams: ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERROR.
  - STATE_W=3 and XLEN=32.
  - The fetch and other stage modules import the same encodings.
- One natural sub-module: `pc_next_unit`. It is combinational and computes pc+4, the branch select, and the misaligned flag.
- FSM, stall counter and retired counter stay in core_sequencer.

Test Plan:
- Reset, then instr_valid=1 held and mem_op=0:
  - state sequence is 0,1,2,4,0.
  - pc is 0 → 4 → 8 across the first three instructions.
  - retired=3 after 12 cycles.
- mem_op=1 in EXEC, mem_done asserted 3 cycles after MEM entry → state holds at 3 for 3 cycles, then 4, then 0. pc advances by 4.
- branch_taken=1 with branch_target=32'h100 in WB → pc=32'h100 in the next FETCH. branch_target=32'h102 → state=7, error=1, pc unchanged.
- FETCH_TIMEOUT=4 and instr_valid held 0 → ERROR after the 5th FETCH cycle. Separately, instr_valid rising exactly on the timeout cycle → DECODE.
- halt_req=1 in DECODE at pc=32'h20 → state=5, halted=1. resume pulse → state=0, pc=32'h24, retired+1.
- Assert rst mid-MEM with pc=32'h40 → immediately state=0, pc=RESET_PC, retired=0. Separately, pc=32'hFFFF_FFFC non-branch WB → pc wraps to 0.
